// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and helpers for the SRAM access arbiter
package sram_arb_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

   // Width of a counter that has to hold every value from 0 to max_lock.
   function automatic int lock_cnt_width(input int max_lock);
      return $clog2(max_lock + 1);
   endfunction

endpackage

// File: rtl/sram_arb_rr_pick.sv
// rtl/sram_arb_rr_pick.sv - two-way round-robin pick with forced-owner override
module sram_arb_rr_pick
   import sram_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               last_owner,
   input  logic               force_en,
   input  logic               force_owner,
   output logic [NUM_REQ-1:0] gnt
);

   // A forced owner wins only if it is requesting; otherwise a tie goes to the requester that did not win last.
   always_comb begin
      gnt = '0;
      if (force_en) begin
         if (req[force_owner]) begin
            gnt[force_owner] = 1'b1;
         end
      end else if (&req) begin
         gnt[~last_owner] = 1'b1;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - round-robin arbiter sharing one single-port SRAM between two requesters
module sram_access_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AW       = 16,
   parameter int MAX_LOCK = 8
)
(
   input  logic          CLK,
   input  logic          RESETn,
   input  logic          M0_REQ,
   input  logic          M0_LOCK,
   input  logic [AW-1:0] M0_ADDR,
   input  logic [31:0]   M0_WDATA,
   input  logic [3:0]    M0_WREN,
   output logic          M0_GNT,
   output logic          M0_RVALID,
   output logic [31:0]   M0_RDATA,
   input  logic          M1_REQ,
   input  logic          M1_LOCK,
   input  logic [AW-1:0] M1_ADDR,
   input  logic [31:0]   M1_WDATA,
   input  logic [3:0]    M1_WREN,
   output logic          M1_GNT,
   output logic          M1_RVALID,
   output logic [31:0]   M1_RDATA,
   output logic [AW-1:0] SRAM_ADDR,
   output logic [31:0]   SRAM_WDATA,
   output logic [3:0]    SRAM_WREN,
   output logic          SRAM_CS,
   input  logic [31:0]   SRAM_RDATA
);

   localparam int             LCW      = lock_cnt_width(MAX_LOCK);
   localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

   arb_state_t         state;
   arb_state_t         state_nxt;
   logic               last_owner;
   logic               last_owner_nxt;
   logic [LCW-1:0]     lock_cnt;
   logic [LCW-1:0]     lock_cnt_nxt;
   logic               rd_pend;
   logic               rd_owner;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [NUM_REQ-1:0] gnt;
   logic               own_valid;
   logic               own_id;
   logic               own_req;
   logic               oth_req;
   logic               force_en;
   logic               force_owner;
   logic               pick_last;
   logic               forced_release;
   logic               gnt_any;
   logic               gnt_id;
   logic               gnt_lock;
   logic               rd_issue;

   assign req       = {M1_REQ, M0_REQ};
   assign own_valid = (state != ARB_IDLE);
   assign own_id    = (state == ARB_OWN1);
   assign own_req   = req[own_id];
   assign oth_req   = req[~own_id];

   // Steer the picker: a requesting lock owner is forced, unless the other side has waited out the lock budget.
   always_comb begin
      force_en       = 1'b0;
      force_owner    = own_id;
      pick_last      = last_owner;
      forced_release = 1'b0;
      if (own_valid) begin
         if (own_req) begin
            force_en = 1'b1;
            if (oth_req && (lock_cnt == LOCK_MAX)) begin
               force_owner    = ~own_id;
               forced_release = 1'b1;
            end
         end else begin
            pick_last = own_id;
         end
      end
   end

   sram_arb_rr_pick u_pick (
      .req         (req),
      .last_owner  (pick_last),
      .force_en    (force_en),
      .force_owner (force_owner),
      .gnt         (pick_gnt)
   );

   // No grant may be seen while reset is held.
   assign gnt      = pick_gnt & {NUM_REQ{RESETn}};
   assign M0_GNT   = gnt[0];
   assign M1_GNT   = gnt[1];
   assign gnt_any  = |gnt;
   assign gnt_id   = gnt[1];
   assign gnt_lock = gnt_id ? M1_LOCK : M0_LOCK;

   assign SRAM_ADDR  = gnt[1] ? M1_ADDR  : M0_ADDR;
   assign SRAM_WDATA = gnt[1] ? M1_WDATA : M0_WDATA;
   assign SRAM_WREN  = gnt[1] ? M1_WREN  : (gnt[0] ? M0_WREN : 4'h0);
   assign SRAM_CS    = gnt_any;
   assign rd_issue   = gnt_any && (SRAM_WREN == 4'h0);

   // Next ownership: a locked grant opens or extends ownership; contested cycles count towards the budget.
   always_comb begin
      state_nxt      = ARB_IDLE;
      lock_cnt_nxt   = '0;
      last_owner_nxt = gnt_any ? gnt_id : last_owner;
      if (gnt_any && !forced_release && gnt_lock) begin
         if (own_valid && (gnt_id == own_id)) begin
            state_nxt    = state;
            lock_cnt_nxt = (oth_req && (lock_cnt != LOCK_MAX)) ? lock_cnt + LCW'(1) : lock_cnt;
         end else begin
            state_nxt    = gnt_id ? ARB_OWN1 : ARB_OWN0;
            lock_cnt_nxt = LCW'(1);
         end
      end
   end

   // Arbitration state registers.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state      <= ARB_IDLE;
         last_owner <= 1'b1;
         lock_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         lock_cnt   <= lock_cnt_nxt;
      end
   end

   // Remember who issued a read so the registered SRAM data goes back to that requester next cycle.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         rd_pend  <= 1'b0;
         rd_owner <= 1'b0;
      end else begin
         rd_pend <= rd_issue;
         if (rd_issue) begin
            rd_owner <= gnt_id;
         end
      end
   end

   assign M0_RVALID = rd_pend & ~rd_owner;
   assign M1_RVALID = rd_pend &  rd_owner;
   assign M0_RDATA  = M0_RVALID ? SRAM_RDATA : 32'h0;
   assign M1_RDATA  = M1_RVALID ? SRAM_RDATA : 32'h0;

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares one single-port FPGA block-RAM instance between two requesters: M0, the CPU-side AHB-to-SRAM bridge, and M1, the DMA/debug port.
- Performs one SRAM access per cycle: a word read or a byte-masked write.
- Arbitration is round-robin, with an optional bounded lock for short bursts.
- Returns pipelined read data, one cycle after the address, to whichever requester issued the read.
- Sits between the requester bridges and the SRAM macro's ADDR/WDATA/WREN/CS/RDATA port.

Parameters:
- AW, 16, SRAM word-address width; must match the SRAM instance.
- MAX_LOCK, 8, maximum consecutive cycles a locked owner keeps the grant while the other requester waits (range 1..255).

Ports:
- CLK  in  1  system clock
- RESETn  in  1  asynchronous active-low reset
- M0_REQ  in  1  M0 access request
- M0_LOCK  in  1  M0 requests to keep ownership after this access
- M0_ADDR  in  AW  M0 word address
- M0_WDATA  in  32  M0 write data
- M0_WREN  in  4  M0 byte write enables; 0 means read
- M0_GNT  out  1  M0 access accepted this cycle
- M0_RVALID  out  1  M0 read data valid
- M0_RDATA  out  32  M0 read data
- M1_REQ, M1_LOCK, M1_ADDR, M1_WDATA, M1_WREN, M1_GNT, M1_RVALID, M1_RDATA: same as M0 for requester 1
- SRAM_ADDR  out  AW  to SRAM ADDR
- SRAM_WDATA  out  32  to SRAM WDATA
- SRAM_WREN  out  4  to SRAM WREN
- SRAM_CS  out  1  to SRAM CS
- SRAM_RDATA  in  32  from SRAM RDATA; valid the cycle after CS

Behaviour:
- Clocking and reset:
  - Single clock CLK; reset is asynchronous and active-low on RESETn.
  - All flops clear on reset: state=ARB_IDLE, last_owner=1 (so M0 wins the first tie), lock_cnt=0, rd_pend=0, rd_owner=0.
- Output values in and after reset:
  - Mx_GNT and Mx_RVALID are 0.
  - Mx_RDATA is 0.
  - SRAM_CS and SRAM_WREN are 0.
- Grant is combinational, in the same cycle as REQ. An access completes when Mx_REQ and Mx_GNT are both high. At most one GNT is high per cycle.
- FSM states: ARB_IDLE, ARB_OWN0, ARB_OWN1.
  - ARB_IDLE:
    - Only one requester active: grant it.
    - Both active: grant the requester that is not last_owner.
    - If the granted requester's LOCK=1, go to ARB_OWNx with lock_cnt=1; otherwise stay in ARB_IDLE.
    - last_owner updates on every grant.
  - ARB_OWNx:
    - Mx_REQ=1 and the other requester idle: grant Mx regardless of lock_cnt.
    - Mx_REQ=1, the other requester active, and lock_cnt<MAX_LOCK: grant Mx and increment lock_cnt.
    - Mx_REQ=1, the other requester active, and lock_cnt==MAX_LOCK: grant the other requester and go to ARB_IDLE. This is the forced release.
    - Mx_REQ=0: behave as ARB_IDLE this cycle, with Mx treated as last_owner.
    - A grant with Mx_LOCK=0 returns the FSM to ARB_IDLE after the access.
    - lock_cnt saturates at MAX_LOCK.
- SRAM drive:
  - SRAM_ADDR, SRAM_WDATA and SRAM_WREN are muxed combinationally from the granted requester.
  - SRAM_CS = M0_GNT | M1_GNT.
  - With no grant: SRAM_WREN=0, SRAM_CS=0, and address/data hold the M0 values (don't-care).
- Read return:
  - A granted access with WREN==0 sets rd_pend=1 and rd_owner=x on the next edge; otherwise rd_pend=0.
  - Mx_RVALID = rd_pend & (rd_owner==x).
  - Mx_RDATA = SRAM_RDATA when Mx_RVALID, else 0.
  - Back-to-back reads, including alternating owners, return data every cycle with no bubble.
- Writes: single cycle, no response; GNT is the completion.
- Write followed by read of the same address in the next cycle returns the new data; the SRAM has write-first behaviour.
- Reset mid-operation: a pending read is discarded (no RVALID), and any lock is dropped.

Decomposition:
- Package sram_arb_pkg holds:
  - the arb_state_t enum (ARB_IDLE, ARB_OWN0, ARB_OWN1);
  - localparam NUM_REQ=2;
  - the lock-counter width function clog2(MAX_LOCK+1).
- One sub-module, sram_arb_rr_pick: combinational two-way round-robin pick from req[1:0], last_owner and a forced-owner override. It returns a one-hot grant.
- Datapath muxes and read-return tracking stay in the top module.

Test Plan:
- Reset: hold RESETn=0 with M0_REQ=1 and M1_REQ=1 → all GNT/RVALID=0, SRAM_CS=0; after release, the first cycle grants M0, the next cycle grants M1.
- M0 writes 0xDEADBEEF to addr 0x0010 (WREN=4'hF), then M1 reads 0x0010 in the next cycle → M1_RVALID=1 one cycle after the read grant, M1_RDATA=0xDEADBEEF, M0_RVALID=0.
- Byte write: M1 writes 0x000000AA with WREN=4'b0001 to a word holding 0x11223344, then M1 reads it → M1_RDATA=0x112233AA.
- Lock limit with MAX_LOCK=8: M0_LOCK=1 and M0_REQ held high, M1_REQ high from cycle 0 → M0 granted 8 consecutive cycles, M1 granted on the 9th, and the FSM returns to ARB_IDLE.
- Alternating back-to-back reads, M0 to 0x0001 and M1 to 0x0002 each cycle, both reqs high → every cycle one GNT, and the RVALIDs alternate with data matching the preloaded words, no gaps.
- Reset asserted the cycle after an M1 read grant → M1_RVALID never asserts; after release, arbitration restarts from ARB_IDLE with M0 winning.
